gp_prefetch_stream: RTL and testbench
=====================================

// Module: gp_prefetch_stream
// PURPOSE
//  Prefetches a graphics-processor command stream from DRAM through the memory controller's
//  address FIFO (af_*) and read-data FIFO (rdf_*). Returns it to the GP as 32-bit words on a
//  valid/ready port. It is a ring of NUM_BLOCKS blocks with configurable burst length.
//  Restart and abort discard in-flight DRAM beats, so a stale burst never reaches the GP.
// PARAMETERS
//  NUM_BLOCKS   2   ring blocks; power of 2, >=2
//  BURST_BEATS  2   128-bit beats per af request (= per block); power of 2, >=1
//  ADDR_W       31  af_addr_din width, in 8-byte DRAM units
// PORTS
//  clk          in   1       clock
//  rst          in   1       async active-high reset
//  start        in   1       pulse: flush and begin streaming at start_addr
//  start_addr   in   32      byte address; low log2(BURST_BEATS*16) bits ignored
//  abort        in   1       pulse: flush and stop fetching
//  af_wr_en     out  1       address request valid
//  af_full      in   1       address FIFO full; request accepted when af_wr_en & !af_full
//  af_addr_din  out  ADDR_W  request address (8-byte units)
//  rdf_valid    in   1       read beat valid
//  rdf_dout     in   128     read beat; word0 = [31:0]
//  rdf_rd_en    out  1       tied 1; space is reserved at request time
//  out_data     out  32      command word
//  out_valid    out  1       out_data valid
//  out_ready    in   1       GP consumes word when out_valid & out_ready
//  busy         out  1       state != IDLE or discard_cnt != 0
// BEHAVIOUR
//  - Reset (async): state IDLE. All block-valid bits, pointers, req_idx, discard_cnt and
//    outstanding = 0. af_wr_en=0, out_valid=0, busy=0, af_addr_din=0. Memory is not reset.
//  - Constants: WPB=4 words/beat; BLOCK_WORDS=BURST_BEATS*4; DEPTH=NUM_BLOCKS*BLOCK_WORDS.
//  - Address: af_addr_din = base + req_idx*BURST_BEATS*2, where base = start_addr>>3 with its
//    low log2(BURST_BEATS*2) bits cleared. Arithmetic is modulo 2^ADDR_W.
//  - FSM states: IDLE, REQ, FILL.
//      IDLE->REQ on start.
//      REQ: af_wr_en=1 only when blk_valid[wr_blk]=0. On accept: req_idx++, outstanding=1, ->FILL.
//      FILL: each rdf beat with discard_cnt==0 is written at wr_blk*BLOCK_WORDS + beat*4.
//            After the last beat: blk_valid[wr_blk]<=1, wr_blk++ (wraps), outstanding=0, ->REQ.
//  - Only one request is outstanding at a time. DRAM returns beats in order.
//  - Read side: out_valid = blk_valid[rd_blk] & state!=IDLE. out_data = mem[rd_blk,rd_word].
//    This is an asynchronous read with zero latency.
//    On pop: rd_word++. On popping the last word: blk_valid[rd_blk]<=0, rd_blk++ (wraps).
//    A freed block can be requested no earlier than the next cycle.
//  - Flush (start or abort):
//      Clear all blk_valid, wr_blk, rd_blk, rd_word and beat counter.
//      discard_cnt <= beats still owed for the outstanding request. A request accepted in the
//      same cycle counts as owed (BURST_BEATS).
//      Beats arriving while discard_cnt>0 are dropped and decrement discard_cnt.
//      start: reload base, req_idx=0, ->REQ. A new request may issue while discards are pending.
//      abort: ->IDLE.
//  - start and abort in the same cycle: start wins.
//  - A rdf beat in the flush cycle counts against the old stream: it is dropped and reduces
//    the owed count.
//  - rdf_valid in IDLE with discard_cnt==0 is a protocol error. Drop the beat; the sim assertion fires.
//  - Latency: start@t gives af_wr_en@t+1. The first out_valid comes 1 cycle after the last beat
//    of the first block is written.
//  - Under steady out_ready=1 and prompt DRAM, the ring fetches ahead and the GP never starves.
// STRUCTURE
//  - gp_prefetch_pkg: state enum, WPB, BEAT_W=128, GP_WORD_W=32.
//  - Sub-module gp_prefetch_ram: DEPTH x 32 distributed RAM. 128-bit beat-granular write port,
//    32-bit async read port. The top holds the FSM, pointers, address and discard logic.
// TESTING
//  - Reset/basic: start, start_addr=0x0040_0000, DRAM returns 8 words 0..7 -> af_addr_din=0x80000,
//    then 0x80004. Words pop in order 0,1,...,7,...
//  - Backpressure: out_ready=0 with defaults -> at most 2 requests accepted. af_wr_en stays 0
//    until the first block is fully popped.
//  - af_full held 5 cycles in REQ -> af_wr_en held with a stable address. Exactly one
//    request is accepted after af_full falls.
//  - Restart mid-burst: start after 1 of 2 beats returns, new addr 0x1000 -> the remaining old
//    beat is dropped. The first popped word comes from the 0x200 request.
//  - Abort with request accepted the same cycle -> discard_cnt=2, busy=1 until both beats drop,
//    out_valid never rises.
//  - Params NUM_BLOCKS=4, BURST_BEATS=4 -> 64-word ring, address step 8. Wrap of rd_blk/wr_blk
//    keeps order over 1000 words.

Source files
------------

// File: rtl/gp_prefetch_pkg.sv
// Shared types and constants for the GP command-stream prefetcher.
package gp_prefetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL
    } state_t;

    localparam int unsigned WPB       = 4;
    localparam int unsigned BEAT_W    = 128;
    localparam int unsigned GP_WORD_W = 32;

endpackage

// File: rtl/gp_prefetch_stream_if.sv
// Memory-controller FIFO ports and GP word port of the prefetcher, bundled.
interface gp_prefetch_stream_if #(
    parameter int unsigned ADDR_W = 31
);
    import gp_prefetch_pkg::*;

    logic                 af_wr_en;
    logic                 af_full;
    logic [ADDR_W-1:0]    af_addr_din;
    logic                 rdf_valid;
    logic [BEAT_W-1:0]    rdf_dout;
    logic                 rdf_rd_en;
    logic [GP_WORD_W-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output af_wr_en, af_addr_din, rdf_rd_en, out_data, out_valid,
        input  af_full, rdf_valid, rdf_dout, out_ready
    );

    modport slave (
        input  af_wr_en, af_addr_din, rdf_rd_en, out_data, out_valid,
        output af_full, rdf_valid, rdf_dout, out_ready
    );

endinterface

// File: rtl/gp_prefetch_ram.sv
// Ring storage: whole-beat writes, single-word asynchronous reads.
module gp_prefetch_ram import gp_prefetch_pkg::*; #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(DEPTH/WPB)-1:0] waddr,
    input  logic [BEAT_W-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0]     raddr,
    output logic [GP_WORD_W-1:0]         rdata
);

    localparam int unsigned WSEL_W = $clog2(WPB);

    logic [GP_WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < WPB; i++) begin
                mem[{waddr, WSEL_W'(i)}] <= wdata[i*GP_WORD_W +: GP_WORD_W];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/gp_prefetch_stream.sv
// Prefetches the GP command stream into a block ring and hands it out word by word.
module gp_prefetch_stream import gp_prefetch_pkg::*; #(
    parameter int unsigned NUM_BLOCKS  = 2,
    parameter int unsigned BURST_BEATS = 2,
    parameter int unsigned ADDR_W      = 31
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [31:0]                 start_addr,
    input  logic                        abort,
    gp_prefetch_stream_if.master        bus,
    output logic                        busy
);

    localparam int unsigned BLOCK_WORDS = BURST_BEATS * WPB;
    localparam int unsigned DEPTH       = NUM_BLOCKS * BLOCK_WORDS;
    localparam int unsigned BLK_W       = $clog2(NUM_BLOCKS);
    localparam int unsigned BEAT_CW     = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam int unsigned WORD_CW     = $clog2(BLOCK_WORDS);
    localparam int unsigned BEAT_AW     = $clog2(DEPTH / WPB);
    localparam int unsigned STEP_SH     = $clog2(BURST_BEATS * 2);
    localparam int unsigned DISC_W      = $clog2(BURST_BEATS) + 6;

    state_t                  state, state_next;
    logic [NUM_BLOCKS-1:0]   blk_valid;
    logic [BLK_W-1:0]        wr_blk, rd_blk;
    logic [WORD_CW-1:0]      rd_word;
    logic [BEAT_CW-1:0]      beat_cnt;
    logic [ADDR_W-1:0]       base, req_idx;
    logic [DISC_W-1:0]       discard_cnt, owed;
    logic                    outstanding;

    logic                    flush, af_wr_en, accept, beat_wr, beat_last;
    logic                    out_valid, pop, pop_last;
    logic [BEAT_AW-1:0]      ram_waddr;
    logic [GP_WORD_W-1:0]    ram_rdata;
    int unsigned             owed_sum;

    always_comb begin
        flush     = start | abort;
        af_wr_en  = (state == REQ) && !blk_valid[wr_blk];
        accept    = af_wr_en && !bus.af_full;
        beat_wr   = (state == FILL) && bus.rdf_valid && (discard_cnt == '0) && !flush;
        beat_last = (beat_cnt == BEAT_CW'(BURST_BEATS - 1));
        out_valid = blk_valid[rd_blk] && (state != IDLE);
        pop       = out_valid && bus.out_ready;
        pop_last  = (rd_word == WORD_CW'(BLOCK_WORDS - 1));
        ram_waddr = BEAT_AW'(32'(wr_blk) * BURST_BEATS + 32'(beat_cnt));
    end

    // Beats still owed by DRAM at a flush; a beat landing in the flush cycle already paid one.
    always_comb begin
        owed_sum = 32'(discard_cnt);
        if (outstanding) owed_sum = owed_sum + BURST_BEATS - 32'(beat_cnt);
        if (accept) owed_sum = owed_sum + BURST_BEATS;
        if (bus.rdf_valid && owed_sum != 0) owed_sum = owed_sum - 1;
        owed = DISC_W'(owed_sum);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = IDLE;
            REQ:     if (accept) state_next = FILL;
            FILL:    if (beat_wr && beat_last) state_next = REQ;
            default: state_next = IDLE;
        endcase
        if (start) state_next = REQ;
        else if (abort) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_valid   <= '0;
            wr_blk      <= '0;
            rd_blk      <= '0;
            rd_word     <= '0;
            beat_cnt    <= '0;
            base        <= '0;
            req_idx     <= '0;
            discard_cnt <= '0;
            outstanding <= 1'b0;
        end else if (flush) begin
            blk_valid   <= '0;
            wr_blk      <= '0;
            rd_blk      <= '0;
            rd_word     <= '0;
            beat_cnt    <= '0;
            outstanding <= 1'b0;
            discard_cnt <= owed;
            if (start) begin
                base    <= ADDR_W'((start_addr >> (3 + STEP_SH)) << STEP_SH);
                req_idx <= '0;
            end
        end else begin
            if (accept) begin
                req_idx     <= req_idx + ADDR_W'(1);
                outstanding <= 1'b1;
            end
            if (bus.rdf_valid && discard_cnt != '0) discard_cnt <= discard_cnt - DISC_W'(1);
            if (beat_wr) begin
                if (beat_last) begin
                    beat_cnt          <= '0;
                    blk_valid[wr_blk] <= 1'b1;
                    wr_blk            <= wr_blk + BLK_W'(1);
                    outstanding       <= 1'b0;
                end else begin
                    beat_cnt <= beat_cnt + BEAT_CW'(1);
                end
            end
            if (pop) begin
                if (pop_last) begin
                    rd_word           <= '0;
                    blk_valid[rd_blk] <= 1'b0;
                    rd_blk            <= rd_blk + BLK_W'(1);
                end else begin
                    rd_word <= rd_word + WORD_CW'(1);
                end
            end
        end
    end

    gp_prefetch_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (beat_wr),
        .waddr (ram_waddr),
        .wdata (bus.rdf_dout),
        .raddr ({rd_blk, rd_word}),
        .rdata (ram_rdata)
    );

    assign bus.af_wr_en    = af_wr_en;
    assign bus.af_addr_din = base + (req_idx << STEP_SH);
    assign bus.rdf_rd_en   = 1'b1;
    assign bus.out_data    = ram_rdata;
    assign bus.out_valid   = out_valid;
    assign busy            = (state != IDLE) || (discard_cnt != '0);

    // A beat in IDLE with nothing owed means DRAM returned data nobody asked for.
    assert property (@(posedge clk) disable iff (rst)
        !(bus.rdf_valid && state == IDLE && discard_cnt == '0));

endmodule

// File: tb/tb_gp_prefetch_stream.sv
// Directed bench: two prefetcher configurations, each fed by a small in-order DRAM model.
module tb_gp_prefetch_stream;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, abort_a, start_b, abort_b;
    logic [31:0] start_addr_a, start_addr_b;
    logic        busy_a, busy_b;
    logic        hold_a;

    int          n_total = 0;
    int          n_bad   = 0;
    int          n;
    int unsigned a0, d0, acc0;

    logic [127:0] bq_a[$], bq_b[$];
    int unsigned  rq_a[$], rq_b[$];
    logic [30:0]  aq_a[$], aq_b[$];
    int unsigned  cyc_a = 0, dlv_a = 0, acc_a = 0;
    int unsigned  cyc_b = 0;

    always #5 clk = ~clk;

    gp_prefetch_stream_if #(.ADDR_W(31)) bus_a ();
    gp_prefetch_stream_if #(.ADDR_W(31)) bus_b ();

    gp_prefetch_stream #(.NUM_BLOCKS(2), .BURST_BEATS(2), .ADDR_W(31)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .start_addr(start_addr_a),
        .abort(abort_a), .bus(bus_a), .busy(busy_a)
    );

    gp_prefetch_stream #(.NUM_BLOCKS(4), .BURST_BEATS(4), .ADDR_W(31)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .start_addr(start_addr_b),
        .abort(abort_b), .bus(bus_b), .busy(busy_b)
    );

    function automatic logic [127:0] make_beat(input logic [30:0] a8, input int unsigned k);
        logic [31:0] w;
        w = {a8, 1'b0} + 32'(k * 4);
        return {w + 32'd3, w + 32'd2, w + 32'd1, w};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    // DRAM model A: drive beats at negedge+1, log requests accepted at the coming edge at negedge+4.
    always @(negedge clk) begin
        #1;
        cyc_a++;
        if (!hold_a && bq_a.size() != 0 && rq_a[0] <= cyc_a) begin
            bus_a.rdf_dout  = bq_a.pop_front();
            void'(rq_a.pop_front());
            bus_a.rdf_valid = 1'b1;
            dlv_a++;
        end else begin
            bus_a.rdf_valid = 1'b0;
        end
        #3;
        if (bus_a.af_wr_en && !bus_a.af_full) begin
            aq_a.push_back(bus_a.af_addr_din);
            acc_a++;
            for (int unsigned k = 0; k < 2; k++) begin
                bq_a.push_back(make_beat(bus_a.af_addr_din, k));
                rq_a.push_back(cyc_a + LAT);
            end
        end
    end

    always @(negedge clk) begin
        #1;
        cyc_b++;
        if (bq_b.size() != 0 && rq_b[0] <= cyc_b) begin
            bus_b.rdf_dout  = bq_b.pop_front();
            void'(rq_b.pop_front());
            bus_b.rdf_valid = 1'b1;
        end else begin
            bus_b.rdf_valid = 1'b0;
        end
        #3;
        if (bus_b.af_wr_en && !bus_b.af_full) begin
            aq_b.push_back(bus_b.af_addr_din);
            for (int unsigned k = 0; k < 4; k++) begin
                bq_b.push_back(make_beat(bus_b.af_addr_din, k));
                rq_b.push_back(cyc_b + LAT);
            end
        end
    end

    task automatic drain_a();
        bus_a.out_ready = 1'b0;
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        hold_a  = 1'b0;
        for (int i = 0; i < 100 && (busy_a || bq_a.size() != 0); i++) step();
        check_eq("drain_idle", {busy_a, bq_a.size() != 0}, 2'b00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; start_addr_a = '0;
        start_b = 1'b0; abort_b = 1'b0; start_addr_b = '0;
        bus_a.af_full = 1'b0; bus_a.out_ready = 1'b0;
        bus_b.af_full = 1'b0; bus_b.out_ready = 1'b0;
        hold_a = 1'b0;
        step();
        step();
        check_eq("rst_af_wr_en", bus_a.af_wr_en, 0);
        check_eq("rst_out_valid", bus_a.out_valid, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_addr", bus_a.af_addr_din, 0);
        check_eq("rst_rd_en", bus_a.rdf_rd_en, 1);
        rst = 1'b0;
        step();
        check_eq("post_rst_busy_b", busy_b, 0);
        check_eq("post_rst_valid_b", bus_b.out_valid, 0);

        // Basic stream: base 0x80000, words count up from 0x100000.
        a0 = aq_a.size();
        start_addr_a = 32'h0040_0000;
        start_a = 1'b1;
        bus_a.out_ready = 1'b1;
        step();
        start_a = 1'b0;
        check_eq("t1_af_wr_en", bus_a.af_wr_en, 1);
        check_eq("t1_addr", bus_a.af_addr_din, 31'h80000);
        check_eq("t1_busy", busy_a, 1);
        n = 0;
        for (int i = 0; i < 300 && n < 16; i++) begin
            if (bus_a.out_valid) begin
                check_eq("t1_word", bus_a.out_data, 32'h0010_0000 + 32'(n));
                n++;
            end
            step();
        end
        check_eq("t1_count", n, 16);
        check_eq("t1_req0", aq_a[a0], 31'h80000);
        check_eq("t1_req1", aq_a[a0 + 1], 31'h80004);
        drain_a();

        // Backpressure: ring fills with two blocks, refetch only after block 0 drains.
        acc0 = acc_a;
        start_addr_a = 32'h0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (40) step();
        check_eq("t2_accepts", acc_a - acc0, 2);
        check_eq("t2_stall", bus_a.af_wr_en, 0);
        check_eq("t2_valid", bus_a.out_valid, 1);
        bus_a.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("t2_word", bus_a.out_data, 32'(i));
            check_eq("t2_hold", bus_a.af_wr_en, 0);
            step();
        end
        bus_a.out_ready = 1'b0;
        check_eq("t2_refetch", bus_a.af_wr_en, 1);
        check_eq("t2_addr", bus_a.af_addr_din, 31'h8);
        drain_a();

        // af_full stall, with start and abort together (start wins).
        acc0 = acc_a;
        start_addr_a = 32'h2000;
        start_a = 1'b1;
        abort_a = 1'b1;
        bus_a.af_full = 1'b1;
        step();
        start_a = 1'b0;
        abort_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("t3_wr_en", bus_a.af_wr_en, 1);
            check_eq("t3_addr", bus_a.af_addr_din, 31'h400);
            step();
        end
        check_eq("t3_none", acc_a - acc0, 0);
        bus_a.af_full = 1'b0;
        step();
        check_eq("t3_one", acc_a - acc0, 1);
        check_eq("t3_fill", bus_a.af_wr_en, 0);
        drain_a();

        // Restart after one of two beats: the stale beat must not surface.
        d0 = dlv_a;
        start_addr_a = 32'h8000;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 50 && dlv_a == d0; i++) step();
        check_eq("t4_beat1", dlv_a - d0, 1);
        hold_a = 1'b1;
        step();
        a0 = aq_a.size();
        start_addr_a = 32'h1000;
        start_a = 1'b1;
        hold_a = 1'b0;
        step();
        start_a = 1'b0;
        bus_a.out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 100 && n < 8; i++) begin
            if (bus_a.out_valid) begin
                check_eq("t4_word", bus_a.out_data, 32'h400 + 32'(n));
                n++;
            end
            step();
        end
        check_eq("t4_count", n, 8);
        check_eq("t4_req", aq_a[a0], 31'h200);
        drain_a();

        // Abort in the same cycle a request is accepted.
        hold_a = 1'b1;
        acc0 = acc_a;
        d0 = dlv_a;
        start_addr_a = 32'h0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check_eq("t5_wr_en", bus_a.af_wr_en, 1);
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        check_eq("t5_accept", acc_a - acc0, 1);
        check_eq("t5_discard", dut_a.discard_cnt, 2);
        for (int i = 0; i < 3; i++) begin
            check_eq("t5_busy", busy_a, 1);
            check_eq("t5_no_valid", bus_a.out_valid, 0);
            step();
        end
        hold_a = 1'b0;
        for (int i = 0; i < 20 && busy_a; i++) begin
            check_eq("t5_no_valid", bus_a.out_valid, 0);
            step();
        end
        check_eq("t5_idle", busy_a, 0);
        check_eq("t5_dropped", dlv_a - d0, 2);

        // 4x4 ring: address step 8, order kept over many wraps with a bursty consumer.
        start_addr_b = 32'h0010_0000;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        n = 0;
        for (int i = 0; i < 8000 && n < 1000; i++) begin
            bus_b.out_ready = ((i % 7) != 2);
            if (bus_b.out_valid && bus_b.out_ready) begin
                check_eq("t6_word", bus_b.out_data, 32'h0004_0000 + 32'(n));
                n++;
            end
            step();
        end
        bus_b.out_ready = 1'b0;
        check_eq("t6_count", n, 1000);
        check_eq("t6_req0", aq_b[0], 31'h20000);
        check_eq("t6_req1", aq_b[1], 31'h20008);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
